// File: rtl/color_cmd_pkg.sv
// Shared types for the colour command sequencer.
// Build option: COLOR_CMD_GAP_EN adds a GAP state that inserts one NOP
// cycle between consecutive queued commands.
package color_cmd_pkg;

    // Command codes as seen on the Color FSM `in` input
    typedef enum logic [1:0] {
        CMD_RED  = 2'h0,
        CMD_BLUE = 2'h1,
        CMD_HSV  = 2'h2,
        CMD_NOP  = 2'h3
    } cmd_t;

`ifdef COLOR_CMD_GAP_EN
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } seq_state_t;
`else
    typedef enum logic {
        IDLE,
        ISSUE
    } seq_state_t;
`endif

    // Value driven on cmd_out while nothing is being issued
    parameter cmd_t CMD_RESET = CMD_NOP;

endpackage

// File: rtl/color_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy and a flush input.
// Push is ignored while full; pop is ignored while empty.
// Flush has priority over push and pop.
module color_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push_en;
    logic             pop_en;

    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem[rd_ptr];
    assign level    = count;

    // Storage write at the tail; contents need no reset
    always_ff @(posedge clk) begin
        if (push_en && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_en && !pop_en) begin
                count <= count + 1'b1;
            end else if (!push_en && pop_en) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/color_cmd_sequencer.sv
// Command stage ahead of the Color FSM: queues {cmd, repeat} pairs and
// holds each command on cmd_out for repeat+1 cycles, NOP when idle.
// Build option: COLOR_CMD_GAP_EN separates consecutive commands with one NOP.
module color_cmd_sequencer
    import color_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [1:0]             push_cmd,
    input  logic [CNT_W-1:0]       push_repeat,
    input  logic                   flush,
    output logic [1:0]             cmd_out,
    output logic                   cmd_active,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = 2 + CNT_W;

    seq_state_t       state;
    seq_state_t       state_d;
    cmd_t             cmd_q;
    cmd_t             cmd_d;
    cmd_t             head_cmd;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] head_rep;
    logic             active_d;
    logic             busy_d;
    logic             push_fire;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [EW-1:0]    fifo_head;
    logic [LW-1:0]    fifo_level;
    logic [LW-1:0]    level_d;

    // Ready uses the registered full flag, so a full FIFO never accepts even on a pop cycle
    assign push_ready = !fifo_full && !flush;
    assign push_fire  = push_valid && push_ready;
    assign head_cmd   = cmd_t'(fifo_head[EW-1 -: 2]);
    assign head_rep   = fifo_head[CNT_W-1:0];
    assign cmd_out    = cmd_q;
    assign level      = fifo_level;

    color_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push_fire),
        .push_data ({push_cmd, push_repeat}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state selection; flush always returns to IDLE
    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == '0) begin
                        if (fifo_empty) begin
                            state_d = IDLE;
                        end
`ifdef COLOR_CMD_GAP_EN
                        else begin
                            state_d = GAP;
                        end
`endif
                    end
                end
`ifdef COLOR_CMD_GAP_EN
                GAP: begin
                    state_d = fifo_empty ? IDLE : ISSUE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Pop, next command, hold counter and active flag for the coming edge
    always_comb begin
        fifo_pop = 1'b0;
        cmd_d    = CMD_RESET;
        cnt_d    = cnt;
        active_d = 1'b0;
        if (flush) begin
            cnt_d = '0;
        end else begin
            case (state)
                ISSUE: begin
                    if (cnt != '0) begin
                        cnt_d    = cnt - 1'b1;
                        cmd_d    = cmd_q;
                        active_d = 1'b1;
                    end
`ifndef COLOR_CMD_GAP_EN
                    else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        cmd_d    = head_cmd;
                        cnt_d    = head_rep;
                        active_d = 1'b1;
                    end
`endif
                end
                default: begin
                    // IDLE and GAP both load the head when one is queued
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        cmd_d    = head_cmd;
                        cnt_d    = head_rep;
                        active_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Occupancy after the coming edge, so busy reflects the same edge's push/pop
    always_comb begin
        level_d = fifo_level;
        if (flush) begin
            level_d = '0;
        end else if (push_fire && !fifo_pop) begin
            level_d = fifo_level + 1'b1;
        end else if (!push_fire && fifo_pop) begin
            level_d = fifo_level - 1'b1;
        end
        busy_d = (state_d != IDLE) || (level_d != '0);
    end

    // Registered outputs and hold counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q      <= CMD_RESET;
            cnt        <= '0;
            cmd_active <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            cnt        <= cnt_d;
            cmd_active <= active_d;
            busy       <= busy_d;
        end
    end

endmodule
